// File: rtl/pipelined_adder.sv
// pipelined_adder: chunked carry-chain adder/subtractor with one register
// stage per chunk, operand skew, sum deskew, valid tracking and clock enable.
module pipelined_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             gclk,
    input  logic             reset,
    input  logic             ce,
    input  logic             in_valid,
    input  logic             mode,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CHUNK = WIDTH / STAGES;

    logic [WIDTH-1:0]  b_eff;
    logic              c_eff;
    logic [STAGES-1:0] cy;
    logic [STAGES-1:0] vld_q;

    assign b_eff = mode ? ~b : b;
    assign c_eff = mode ? ~cin : cin;

    always_ff @(posedge gclk) begin
        if (reset) begin
            vld_q <= '0;
        end else if (ce) begin
            vld_q[0] <= in_valid;
            for (int j = 1; j < STAGES; j++) begin
                vld_q[j] <= vld_q[j-1];
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign cout      = cy[STAGES-1];

    for (genvar k = 0; k < STAGES; k++) begin : g_ch
        localparam int D = STAGES - 1 - k;

        logic [CHUNK-1:0] op_a;
        logic [CHUNK-1:0] op_b;
        logic             cin_k;
        logic [CHUNK:0]   add_d;
        logic [CHUNK-1:0] s_q;
        logic             c_q;

        if (k == 0) begin : g_in
            assign op_a  = a[CHUNK-1:0];
            assign op_b  = b_eff[CHUNK-1:0];
            assign cin_k = c_eff;
        end else begin : g_skew
            // Chunk k waits k cycles for the carry rippling up from below.
            logic [CHUNK-1:0] ska_q [k];
            logic [CHUNK-1:0] skb_q [k];

            always_ff @(posedge gclk) begin
                if (reset) begin
                    for (int j = 0; j < k; j++) begin
                        ska_q[j] <= '0;
                        skb_q[j] <= '0;
                    end
                end else if (ce) begin
                    ska_q[0] <= a[k*CHUNK +: CHUNK];
                    skb_q[0] <= b_eff[k*CHUNK +: CHUNK];
                    for (int j = 1; j < k; j++) begin
                        ska_q[j] <= ska_q[j-1];
                        skb_q[j] <= skb_q[j-1];
                    end
                end
            end

            assign op_a  = ska_q[k-1];
            assign op_b  = skb_q[k-1];
            assign cin_k = cy[k-1];
        end

        assign add_d = {1'b0, op_a} + {1'b0, op_b} + {{CHUNK{1'b0}}, cin_k};

        always_ff @(posedge gclk) begin
            if (reset) begin
                s_q <= '0;
                c_q <= 1'b0;
            end else if (ce) begin
                s_q <= add_d[CHUNK-1:0];
                c_q <= add_d[CHUNK];
            end
        end

        assign cy[k] = c_q;

        if (k == STAGES - 1) begin : g_top
            logic ovf_q;

            always_ff @(posedge gclk) begin
                if (reset) begin
                    ovf_q <= 1'b0;
                end else if (ce) begin
                    ovf_q <= (op_a[CHUNK-1] == op_b[CHUNK-1]) &&
                             (add_d[CHUNK-1] != op_a[CHUNK-1]);
                end
            end

            assign ovf = ovf_q;
        end

        if (D == 0) begin : g_nodsk
            assign sum[k*CHUNK +: CHUNK] = s_q;
        end else begin : g_dsk
            // Lower chunks finish early and are held until the top lands.
            logic [CHUNK-1:0] dsk_q [D];

            always_ff @(posedge gclk) begin
                if (reset) begin
                    for (int j = 0; j < D; j++) begin
                        dsk_q[j] <= '0;
                    end
                end else if (ce) begin
                    dsk_q[0] <= s_q;
                    for (int j = 1; j < D; j++) begin
                        dsk_q[j] <= dsk_q[j-1];
                    end
                end
            end

            assign sum[k*CHUNK +: CHUNK] = dsk_q[D-1];
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: three configurations driven with shared stimulus and
// checked against an arithmetic reference with per-config delay queues.
module tb_pipelined_adder;

    typedef struct packed {
        logic        v;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } res_t;

    logic        gclk;
    logic        reset;
    logic        ce;
    logic        in_valid;
    logic        mode;
    logic        cin;
    logic [31:0] a_r;
    logic [31:0] b_r;

    logic        v8,  co8,  ov8;
    logic [7:0]  s8;
    logic        v2,  co2,  ov2;
    logic [1:0]  s2;
    logic        v16, co16, ov16;
    logic [15:0] s16;

    int   n_cmp;
    int   n_err;
    res_t q8[$];
    res_t q2[$];
    res_t q16[$];
    res_t e8, e2, e16;
    bit   zwin;
    bit   zforce;

    pipelined_adder #(.WIDTH(8), .STAGES(2)) u_d8 (
        .gclk(gclk), .reset(reset), .ce(ce), .in_valid(in_valid),
        .mode(mode), .cin(cin), .a(a_r[7:0]), .b(b_r[7:0]),
        .out_valid(v8), .sum(s8), .cout(co8), .ovf(ov8)
    );

    pipelined_adder #(.WIDTH(2), .STAGES(1)) u_d2 (
        .gclk(gclk), .reset(reset), .ce(ce), .in_valid(in_valid),
        .mode(mode), .cin(cin), .a(a_r[1:0]), .b(b_r[1:0]),
        .out_valid(v2), .sum(s2), .cout(co2), .ovf(ov2)
    );

    pipelined_adder #(.WIDTH(16), .STAGES(4)) u_d16 (
        .gclk(gclk), .reset(reset), .ce(ce), .in_valid(in_valid),
        .mode(mode), .cin(cin), .a(a_r[15:0]), .b(b_r[15:0]),
        .out_valid(v16), .sum(s16), .cout(co16), .ovf(ov16)
    );

    initial begin
        gclk = 1'b0;
        forever #5 gclk = ~gclk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic res_t ref_add(input int w, input logic v,
                                     input logic [31:0] a, input logic [31:0] b,
                                     input logic m, input logic c);
        logic [31:0] mask, aa, be, s;
        logic [32:0] full;
        res_t r;
        mask = (32'h1 << w) - 32'h1;
        aa   = a & mask;
        be   = (m ? ~b : b) & mask;
        full = {1'b0, aa} + {1'b0, be} + {32'b0, (m ? ~c : c)};
        s    = full[31:0] & mask;
        r.v  = v;
        r.s  = s[15:0];
        r.co = full[w];
        r.ov = (aa[w-1] == be[w-1]) && (s[w-1] != aa[w-1]);
        return r;
    endfunction

    task automatic reset_q(input int lat, output res_t q[$]);
        q = {};
        for (int i = 0; i < lat - 1; i++) q.push_back('0);
    endtask

    task automatic model_edge();
        zwin = 1'b0;
        if (reset) begin
            reset_q(2, q8);
            reset_q(1, q2);
            reset_q(4, q16);
            e8 = '0; e2 = '0; e16 = '0;
            zwin = 1'b1;
        end else if (ce) begin
            q8.push_back(ref_add(8, in_valid, a_r, b_r, mode, cin));
            q2.push_back(ref_add(2, in_valid, a_r, b_r, mode, cin));
            q16.push_back(ref_add(16, in_valid, a_r, b_r, mode, cin));
            e8  = q8.pop_front();
            e2  = q2.pop_front();
            e16 = q16.pop_front();
        end
    endtask

    task automatic check_dut(input string n, input logic v, input logic [15:0] s,
                             input logic co, input logic ov, input res_t e);
        chk({n, ".valid"}, 32'(v), 32'(e.v));
        if (e.v || zwin || zforce) begin
            chk({n, ".sum"}, 32'(s), 32'(e.s));
            chk({n, ".cout"}, 32'(co), 32'(e.co));
            chk({n, ".ovf"}, 32'(ov), 32'(e.ov));
        end
    endtask

    task automatic cycle();
        @(posedge gclk);
        model_edge();
        #1;
        check_dut("w8", v8, 16'(s8), co8, ov8, e8);
        check_dut("w2", v2, 16'(s2), co2, ov2, e2);
        check_dut("w16", v16, s16, co16, ov16, e16);
    endtask

    task automatic op(input logic v, input logic m, input logic c,
                      input logic [31:0] a, input logic [31:0] b);
        in_valid = v;
        mode     = m;
        cin      = c;
        a_r      = a;
        b_r      = b;
        cycle();
    endtask

    task automatic rnd_op(input logic v);
        op(v, 1'($urandom), 1'($urandom), $urandom, $urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        zwin = 1'b0; zforce = 1'b0;
        e8 = '0; e2 = '0; e16 = '0;
        reset_q(2, q8); reset_q(1, q2); reset_q(4, q16);
        reset = 1'b1; ce = 1'b1;
        in_valid = 1'b1; mode = 1'b0; cin = 1'b0;
        a_r = 32'h55; b_r = 32'h0;

        for (int i = 0; i < 3; i++) op(1'b1, 1'b0, 1'b0, 32'h55, 32'h0);
        reset = 1'b0;
        zforce = 1'b1;
        idle(2);
        zforce = 1'b0;

        op(1'b1, 1'b0, 1'b0, 32'hFF, 32'h01);
        op(1'b1, 1'b0, 1'b0, 32'h7F, 32'h01);
        op(1'b1, 1'b1, 1'b0, 32'h80, 32'h01);
        op(1'b1, 1'b1, 1'b1, 32'h00, 32'h01);
        op(1'b1, 1'b0, 1'b0, 32'h01, 32'h01);
        op(1'b1, 1'b0, 1'b0, 32'hFFFF, 32'h0001);
        op(1'b1, 1'b1, 1'b0, 32'h8000, 32'h0001);
        idle(5);

        for (int i = 0; i < 32; i++) rnd_op(1'b1);
        for (int i = 0; i < 24; i++) rnd_op(logic'($urandom_range(0, 3) != 0));
        idle(5);

        rnd_op(1'b1);
        rnd_op(1'b1);
        ce = 1'b0;
        for (int i = 0; i < 3; i++) rnd_op(1'b1);
        ce = 1'b1;
        idle(5);

        rnd_op(1'b1);
        rnd_op(1'b1);
        reset = 1'b1;
        ce = 1'b0;
        rnd_op(1'b1);
        reset = 1'b0;
        ce = 1'b1;
        rnd_op(1'b1);
        idle(5);

        for (int i = 0; i < 60; i++) begin
            ce = logic'($urandom_range(0, 4) != 0);
            rnd_op(logic'($urandom_range(0, 3) != 0));
        end
        ce = 1'b1;
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
